// File: rtl/line_centroid.sv
// line_centroid: per-frame ROI centroid column estimator for a 4-bit edge-magnitude raster stream.
// Ports: clk, rst (async, active-high), pixel_in[3:0], in_ready -> centroid_x[CX_W-1:0], line_valid, line_lost.
// Optional macro ROW_CENTROID_EN adds row_centroid_x[CX_W-1:0] and row_valid (per-ROI-row centroid).
module lc_div #(
  parameter int NW = 25,
  parameter int DW = 16,
  parameter int QW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [NW-1:0] num_i,
  input  logic [DW-1:0] den_i,
  output logic [QW-1:0] q_o,
  output logic          valid_o,
  output logic          lost_o
);
  localparam int TW = (NW > DW + QW) ? NW : DW + QW;
  typedef enum logic [1:0] {ACCUM, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [NW-1:0] rem_q, rem_d;
  logic [DW-1:0] den_q, den_d;
  logic [QW-1:0] quo_q, quo_d, q_q, q_d;
  logic [$clog2(QW)-1:0] k_q, k_d;
  logic valid_q, valid_d, lost_q, lost_d;
  logic [TW-1:0] trial;
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    den_d = den_q;
    quo_d = quo_q;
    k_d = k_q;
    q_d = q_q;
    valid_d = 1'b0;
    lost_d = lost_q;
    trial = TW'(den_q) << k_q;
    if (state_q == DIV) begin
      if (TW'(rem_q) >= trial) begin
        rem_d = rem_q - NW'(trial);
        quo_d[k_q] = 1'b1;
      end
      k_d = k_q - 1'b1;
      state_d = (k_q == '0) ? DONE : DIV;
    end else if (state_q == DONE) begin
      state_d = ACCUM;
      valid_d = 1'b1;
      q_d = quo_q;
      lost_d = (den_q == '0);
    end
    if (start_i) begin
      state_d = DIV;
      rem_d = num_i;
      den_d = den_i;
      quo_d = '0;
      k_d = $clog2(QW)'(QW - 1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      rem_q <= '0;
      den_q <= '0;
      quo_q <= '0;
      k_q <= '0;
      q_q <= '0;
      valid_q <= 1'b0;
      lost_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      den_q <= den_d;
      quo_q <= quo_d;
      k_q <= k_d;
      q_q <= q_d;
      valid_q <= valid_d;
      lost_q <= lost_d;
    end
  end
  // an empty divisor leaves an all-ones quotient, so the reported column is masked to 0
  assign q_o = lost_q ? '0 : q_q;
  assign valid_o = valid_q;
  assign lost_o = lost_q;
endmodule

module line_centroid #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int ROI_HEIGHT = 60,
  parameter int THRESHOLD = 0,
  localparam int CX_W = $clog2(IMG_W) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      pixel_in,
  input  logic            in_ready,
  output logic [CX_W-1:0] centroid_x,
  output logic            line_valid,
`ifdef ROW_CENTROID_EN
  output logic [CX_W-1:0] row_centroid_x,
  output logic            row_valid,
`endif
  output logic            line_lost
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int SUM_W = $clog2(IMG_W * IMG_W * ROI_HEIGHT);
  localparam int CNT_W = $clog2(IMG_W * ROI_HEIGHT + 1);
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [SUM_W-1:0] sum_q, sum_d, sum_nx;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nx;
  logic in_roi, hit, x_end, frame_end;
  always_comb begin
    in_roi = y_q >= YW'(IMG_H - ROI_HEIGHT);
    hit = in_ready && in_roi && (pixel_in > 4'(THRESHOLD));
    x_end = x_q == XW'(IMG_W - 1);
    frame_end = in_ready && x_end && (y_q == YW'(IMG_H - 1));
    x_d = in_ready ? (x_end ? '0 : x_q + 1'b1) : x_q;
    y_d = (in_ready && x_end) ? ((y_q == YW'(IMG_H - 1)) ? '0 : y_q + 1'b1) : y_q;
    sum_nx = hit ? sum_q + SUM_W'(x_q) : sum_q;
    cnt_nx = hit ? cnt_q + 1'b1 : cnt_q;
    sum_d = frame_end ? '0 : sum_nx;
    cnt_d = frame_end ? '0 : cnt_nx;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      sum_q <= '0;
      cnt_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      sum_q <= sum_d;
      cnt_q <= cnt_d;
    end
  end
  // the divider snapshots the sums including the final pixel while the accumulators clear
  lc_div #(.NW(SUM_W), .DW(CNT_W), .QW(CX_W)) u_frame_div (
    .clk(clk), .rst(rst), .start_i(frame_end), .num_i(sum_nx), .den_i(cnt_nx),
    .q_o(centroid_x), .valid_o(line_valid), .lost_o(line_lost)
  );
`ifdef ROW_CENTROID_EN
  localparam int RSUM_W = $clog2(IMG_W * IMG_W);
  localparam int RCNT_W = $clog2(IMG_W + 1);
  logic [RSUM_W-1:0] rsum_q, rsum_d, rsum_nx;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d, rcnt_nx;
  logic row_end, row_lost;
  always_comb begin
    row_end = in_ready && x_end && in_roi;
    rsum_nx = hit ? rsum_q + RSUM_W'(x_q) : rsum_q;
    rcnt_nx = hit ? rcnt_q + 1'b1 : rcnt_q;
    rsum_d = row_end ? '0 : rsum_nx;
    rcnt_d = row_end ? '0 : rcnt_nx;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsum_q <= '0;
      rcnt_q <= '0;
    end else begin
      rsum_q <= rsum_d;
      rcnt_q <= rcnt_d;
    end
  end
  lc_div #(.NW(RSUM_W), .DW(RCNT_W), .QW(CX_W)) u_row_div (
    .clk(clk), .rst(rst), .start_i(row_end), .num_i(rsum_nx), .den_i(rcnt_nx),
    .q_o(row_centroid_x), .valid_o(row_valid), .lost_o(row_lost)
  );
`endif
endmodule

// File: tb/tb_line_centroid.sv
// tb_line_centroid: directed frames against two instances (THRESHOLD 0 and 5) of line_centroid.
module tb_line_centroid;
  localparam int W = 640;
  localparam int H = 6;
  localparam int R = 2;
  localparam int CXW = 11;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_ready = 1'b0;
  logic [3:0] pixel_in = 4'd0;
  logic [CXW-1:0] cx0, cx5;
  logic v0, v5, l0, l5;
`ifdef ROW_CENTROID_EN
  logic [CXW-1:0] rc0, rc5;
  logic rv0, rv5;
`endif
  line_centroid #(.IMG_W(W), .IMG_H(H), .ROI_HEIGHT(R), .THRESHOLD(0)) dut (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .in_ready(in_ready),
    .centroid_x(cx0), .line_valid(v0),
`ifdef ROW_CENTROID_EN
    .row_centroid_x(rc0), .row_valid(rv0),
`endif
    .line_lost(l0)
  );
  line_centroid #(.IMG_W(W), .IMG_H(H), .ROI_HEIGHT(R), .THRESHOLD(5)) dut5 (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .in_ready(in_ready),
    .centroid_x(cx5), .line_valid(v5),
`ifdef ROW_CENTROID_EN
    .row_centroid_x(rc5), .row_valid(rv5),
`endif
    .line_lost(l5)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  int last_edge = 0;
  int npulse = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {int c0; int l0; int c5; int l5; int v5; int lat;} res_t;
  res_t rq[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (v0 || v5) begin
      rq.push_back('{int'(cx0), int'(l0), int'(cx5), int'(l5), int'(v5), cyc - last_edge});
      npulse++;
    end
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] pix(input int m, input int x, input int y);
    case (m)
      0: return 4'd0;
      1: return (x == 320) ? 4'd15 : 4'd0;
      2: return (x == 320 && y < H - R) ? 4'd15 : 4'd0;
      3: return (x == 10 || x == 13) ? 4'd15 : 4'd0;
      4: return (x == 100 || x == 300) ? 4'd15 : 4'd0;
      5: return (x == 50) ? 4'd5 : ((x == 400) ? 4'd6 : 4'd0);
      6: return 4'd5;
      7: return (x == 100) ? 4'd15 : 4'd0;
      8: return (x == 500) ? 4'd15 : 4'd0;
      9: return (x == 639) ? 4'd15 : 4'd0;
      default: return (x == 7) ? 4'd15 : 4'd0;
    endcase
  endfunction
  task automatic frame(input int m, input bit gap, input int rows, input bit stop);
    for (int y = 0; y < rows; y++)
      for (int x = 0; x < W; x++) begin
        if (gap)
          while ($urandom_range(1, 0) == 1) begin
            @(negedge clk);
            in_ready = 1'b0;
          end
        @(negedge clk);
        pixel_in = pix(m, x, y);
        in_ready = 1'b1;
        if (x == W - 1 && y == H - 1) last_edge = cyc + 1;
      end
    if (stop) begin
      @(negedge clk);
      in_ready = 1'b0;
      pixel_in = 4'd0;
    end
  endtask
  task automatic exp_frame(input string tag, input int c0, input int el0, input int c5, input int el5);
    res_t r;
    int n = 0;
    while (rq.size() == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() == 0) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end
    r = rq.pop_front();
    chk({tag, "_cx"}, r.c0, c0);
    chk({tag, "_lost"}, r.l0, el0);
    chk({tag, "_cx5"}, r.c5, c5);
    chk({tag, "_lost5"}, r.l5, el5);
    chk({tag, "_v5"}, r.v5, 1);
    chk({tag, "_lat"}, r.lat, CXW + 1);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cx", int'(cx0), 0);
    chk("rst_lost", int'(l0), 0);
    chk("rst_valid", int'(v0), 0);
    rst = 1'b0;
    frame(0, 0, H, 1); exp_frame("zero", 0, 1, 0, 1);
    frame(1, 0, H, 1); exp_frame("vline", 320, 0, 320, 0);
    frame(2, 0, H, 1); exp_frame("above_roi", 0, 1, 0, 1);
    frame(3, 0, H, 1); exp_frame("c10_13", 11, 0, 11, 0);
    frame(4, 0, H, 1); exp_frame("c100_300", 200, 0, 200, 0);
    frame(5, 0, H, 1); exp_frame("thresh", 225, 0, 400, 0);
    frame(6, 0, H, 1); exp_frame("all5", 319, 0, 0, 1);
    frame(7, 0, H, 0);
    frame(8, 0, H, 1);
    exp_frame("b2b_a", 100, 0, 100, 0);
    exp_frame("b2b_b", 500, 0, 500, 0);
    frame(9, 1, H, 1); exp_frame("gapped", 639, 0, 639, 0);
    frame(7, 0, H, 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("middiv_rst_cx", int'(cx0), 0);
    rst = 1'b0;
    frame(10, 0, 3, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("no_pulse", rq.size(), 0);
    frame(10, 0, H, 1); exp_frame("clean", 7, 0, 7, 0);
    repeat (20) @(negedge clk);
    chk("pulses", npulse, 11);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
